// File: rtl/instr_sequencer.sv
// Multi-cycle phase controller: walks one instruction at a time through
// FETCH..WRITEBACK and emits one-cycle enable strobes on a single clock.
module instr_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             branch,
  input  logic             uncondbranch,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             rf_read_en,
  output logic             ex_en,
  output logic             rf_write_en,
  output logic             pc_write,
  output logic             mem_en,
  output logic             pc_src,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_READ      = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEMORY    = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             mem_read_l, mem_write_l, reg_write_l, branch_l, uncond_l;
  logic             taken_l, halt_pending, fault_q;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] instr_cnt, cycle_cnt;

  logic complete, timeout, taken_now, halt_now;

  // Memory handshake: while in MEMORY, mem_en is held high; the access is
  // finished in the cycle mem_ready=1 is sampled, and wait_cnt counts every
  // MEMORY cycle seen with mem_ready=0 until MEM_TIMEOUT forces a fault.
  always_comb begin
    state_d   = state_q;
    complete  = 1'b0;
    timeout   = 1'b0;
    taken_now = uncond_l | (branch_l & alu_zero);
    halt_now  = halt_pending | halt_req;
    case (state_q)
      S_IDLE:    if (start) state_d = halt_now ? S_HALT : S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = S_READ;
      S_READ:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (mem_read_l | mem_write_l) state_d = S_MEMORY;
        else if (reg_write_l)         state_d = S_WRITEBACK;
        else                          complete = 1'b1;
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (mem_read_l & reg_write_l) state_d = S_WRITEBACK;
          else                          complete = 1'b1;
        end else if (wait_cnt >= WAIT_LAST) begin
          state_d = S_HALT;
          timeout = 1'b1;
        end
      end
      S_WRITEBACK: complete = 1'b1;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
    if (complete) state_d = halt_now ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mem_read_l   <= 1'b0;
      mem_write_l  <= 1'b0;
      reg_write_l  <= 1'b0;
      branch_l     <= 1'b0;
      uncond_l     <= 1'b0;
      taken_l      <= 1'b0;
      halt_pending <= 1'b0;
      fault_q      <= 1'b0;
      wait_cnt     <= 8'd0;
      instr_cnt    <= '0;
      cycle_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (halt_req) halt_pending <= 1'b1;
      if (timeout)  fault_q <= 1'b1;
      if (state_q == S_READ) begin
        mem_read_l  <= mem_read;
        mem_write_l <= mem_write;
        reg_write_l <= reg_write;
        branch_l    <= branch;
        uncond_l    <= uncondbranch;
      end
      if (state_q == S_EXECUTE) taken_l <= taken_now;
      if (state_q != S_MEMORY)  wait_cnt <= 8'd0;
      else if (!mem_ready)      wait_cnt <= wait_cnt + 8'd1;
      if (complete && instr_cnt != '1) instr_cnt <= instr_cnt + 1'b1;
      if (state_q != S_IDLE && state_q != S_HALT && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign fetch_en    = (state_q == S_FETCH);
  assign decode_en   = (state_q == S_DECODE);
  assign rf_read_en  = (state_q == S_READ);
  assign ex_en       = (state_q == S_EXECUTE);
  assign rf_write_en = (state_q == S_WRITEBACK);
  assign mem_en      = (state_q == S_MEMORY);
  assign pc_write    = complete;
  // EXECUTE completes in the same cycle the branch is resolved, so use it live.
  assign pc_src      = complete & ((state_q == S_EXECUTE) ? taken_now : taken_l);
  assign state       = state_q;
  assign fault       = fault_q;
  assign instr_count = instr_cnt;
  assign cycle_count = cycle_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: walks R-type, CBZ, B, LDUR, STUR timeout,
// halt and mid-instruction reset, with hand-computed expected values.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, halt_req = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
  logic        branch = 1'b0, uncondbranch = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
  logic        fetch_en, decode_en, rf_read_en, ex_en, rf_write_en, pc_write;
  logic        mem_en, pc_src, fault;
  logic [2:0]  state;
  logic [31:0] instr_count, cycle_count;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  instr_sequencer #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .branch(branch), .uncondbranch(uncondbranch), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .fetch_en(fetch_en), .decode_en(decode_en),
    .rf_read_en(rf_read_en), .ex_en(ex_en), .rf_write_en(rf_write_en),
    .pc_write(pc_write), .mem_en(mem_en), .pc_src(pc_src), .state(state),
    .fault(fault), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_ctl(input logic mr, input logic mw, input logic rw,
                         input logic br, input logic ub, input logic az);
    mem_read = mr; mem_write = mw; reg_write = rw;
    branch = br; uncondbranch = ub; alu_zero = az;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
    set_ctl(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_state", 32'(state), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // advance one cycle and compare the state seen mid-cycle
  task automatic expect_state(input string tag, input logic [2:0] s);
    @(negedge clk);
    #1;
    check(tag, 32'(state), 32'(s));
  endtask

  initial begin
    // ---- reset values ----
    rst = 1'b0;
    #2;
    check("rst_async_state", 32'(state), 0);
    check("rst_strobes", 32'({fetch_en, decode_en, rf_read_en, ex_en, rf_write_en,
                             pc_write, mem_en, pc_src, fault}), 0);
    check("rst_counts", instr_count | cycle_count, 0);

    // ---- R-type ----
    do_reset();
    set_ctl(0, 0, 1, 0, 0, 0);
    start = 1'b1;
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    while (exp_q.size() > 0) begin
      logic [2:0] s;
      s = exp_q.pop_front();
      expect_state("rtype_state", s);
      if (s == 3'd1) check("rtype_fetch_en", 32'(fetch_en), 1);
      if (s == 3'd4) check("rtype_ex_nopc", 32'(pc_write), 0);
    end
    check("rtype_pc_write", 32'(pc_write), 1);
    check("rtype_pc_src", 32'(pc_src), 0);
    check("rtype_rf_write_en", 32'(rf_write_en), 1);
    expect_state("rtype_next_fetch", 3'd1);
    check("rtype_instr_count", instr_count, 1);
    check("rtype_cycle_count", cycle_count, 5);

    // ---- CBZ taken then not taken ----
    do_reset();
    set_ctl(0, 0, 0, 1, 0, 1);
    start = 1'b1;
    expect_state("cbz_f", 3'd1);
    expect_state("cbz_d", 3'd2);
    expect_state("cbz_r", 3'd3);
    expect_state("cbz_e", 3'd4);
    check("cbz_pc_write", 32'(pc_write), 1);
    check("cbz_pc_src", 32'(pc_src), 1);
    check("cbz_no_rf_write", 32'(rf_write_en), 0);
    expect_state("cbz_next", 3'd1);
    check("cbz_cycle_count", cycle_count, 4);
    alu_zero = 1'b0;
    expect_state("cbz2_d", 3'd2);
    expect_state("cbz2_r", 3'd3);
    expect_state("cbz2_e", 3'd4);
    check("cbz2_pc_write", 32'(pc_write), 1);
    check("cbz2_pc_src", 32'(pc_src), 0);
    expect_state("cbz2_next", 3'd1);
    check("cbz2_instr_count", instr_count, 2);

    // ---- LDUR, mem_ready low 3 cycles ----
    do_reset();
    set_ctl(1, 0, 1, 0, 0, 0);
    start = 1'b1;
    expect_state("ldur_f", 3'd1);
    expect_state("ldur_d", 3'd2);
    expect_state("ldur_r", 3'd3);
    expect_state("ldur_e", 3'd4);
    for (int i = 0; i < 3; i++) begin
      expect_state("ldur_mem_wait", 3'd5);
      check("ldur_mem_en", 32'(mem_en), 1);
    end
    expect_state("ldur_mem_last", 3'd5);
    mem_ready = 1'b1;
    #1;
    check("ldur_mem_en_last", 32'(mem_en), 1);
    check("ldur_mem_nopc", 32'(pc_write), 0);
    expect_state("ldur_wb", 3'd6);
    mem_ready = 1'b0;
    check("ldur_pc_write", 32'(pc_write), 1);
    expect_state("ldur_next", 3'd1);
    check("ldur_latency", cycle_count, 9);
    check("ldur_instr_count", instr_count, 1);

    // ---- STUR, memory never ready -> timeout ----
    do_reset();
    set_ctl(0, 1, 0, 0, 0, 0);
    start = 1'b1;
    expect_state("stur_f", 3'd1);
    expect_state("stur_d", 3'd2);
    expect_state("stur_r", 3'd3);
    expect_state("stur_e", 3'd4);
    for (int i = 0; i < 15; i++) begin
      expect_state("stur_mem", 3'd5);
      check("stur_no_pc_write", 32'(pc_write), 0);
      check("stur_no_fault_yet", 32'(fault), 0);
    end
    expect_state("stur_halt", 3'd7);
    check("stur_fault", 32'(fault), 1);
    check("stur_instr_count", instr_count, 0);
    check("stur_cycle_count", cycle_count, 19);
    expect_state("stur_halt_stays", 3'd7);
    check("stur_cycle_frozen", cycle_count, 19);

    // ---- B with halt_req during DECODE ----
    do_reset();
    set_ctl(0, 0, 0, 0, 1, 0);
    start = 1'b1;
    expect_state("b_f", 3'd1);
    expect_state("b_d", 3'd2);
    halt_req = 1'b1;
    expect_state("b_r", 3'd3);
    halt_req = 1'b0;
    expect_state("b_e", 3'd4);
    check("b_pc_write", 32'(pc_write), 1);
    check("b_pc_src", 32'(pc_src), 1);
    expect_state("b_halt", 3'd7);
    for (int i = 0; i < 3; i++) expect_state("b_halt_hold", 3'd7);
    check("b_cycle_frozen", cycle_count, 4);
    check("b_instr_count", instr_count, 1);
    check("b_fault_clear", 32'(fault), 0);

    // ---- reset asserted mid-MEMORY ----
    do_reset();
    set_ctl(1, 0, 1, 0, 0, 0);
    start = 1'b1;
    expect_state("mrst_f", 3'd1);
    expect_state("mrst_d", 3'd2);
    expect_state("mrst_r", 3'd3);
    expect_state("mrst_e", 3'd4);
    expect_state("mrst_m", 3'd5);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_state", 32'(state), 0);
    check("mrst_outputs", 32'({fetch_en, decode_en, rf_read_en, ex_en, rf_write_en,
                              pc_write, mem_en, pc_src, fault}), 0);
    check("mrst_counts", instr_count | cycle_count, 0);
    @(negedge clk);
    rst = 1'b1;
    set_ctl(0, 0, 1, 0, 0, 0);
    mem_ready = 1'b1;
    expect_state("mrst_restart", 3'd1);
    check("mrst_cycle_zero", cycle_count, 0);
    check("mrst_instr_zero", instr_count, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
